// File: rtl/cache_data_array_nway.sv
// rtl/cache_data_array_nway.sv - N-way set-associative cache data store with registered all-ways read port, store-hit write port and line-fill sequencer
module cache_data_array_nway #(
  parameter int SETS   = 64,
  parameter int WAYS   = 2,
  parameter int WORDS  = 8,
  parameter int DATA_W = 16,
  localparam int SET_W  = $clog2(SETS),
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int WORD_W = $clog2(WORDS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [SET_W-1:0]         rd_set,
  input  logic [WORD_W-1:0]        rd_word,
  output logic [WAYS*DATA_W-1:0]   rd_data,
  output logic                     rd_valid,
  input  logic                     wr_en,
  input  logic [SET_W-1:0]         wr_set,
  input  logic [WAY_W-1:0]         wr_way,
  input  logic [WORD_W-1:0]        wr_word,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     fill_start,
  input  logic [SET_W-1:0]         fill_set,
  input  logic [WAY_W-1:0]         fill_way,
  input  logic                     fill_in_valid,
  input  logic [DATA_W-1:0]        fill_data,
  output logic                     fill_busy,
  output logic                     fill_done
);

  typedef enum logic {IDLE, FILL} state_t;

  logic [DATA_W-1:0] mem [SETS][WAYS][WORDS];
  state_t            state;
  logic [WORD_W-1:0] cnt;
  logic [SET_W-1:0]  fill_set_q;
  logic [WAY_W-1:0]  fill_way_q;
  logic              wr_blocked;

  // The line being filled belongs to the sequencer; store hits to it are discarded.
  assign wr_blocked = (state == FILL) && (wr_set == fill_set_q) && (wr_way == fill_way_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          for (int k = 0; k < WORDS; k++)
            mem[s][w][k] <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      fill_busy  <= 1'b0;
      fill_done  <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      fill_set_q <= '0;
      fill_way_q <= '0;
    end else begin
      rd_valid  <= rd_en;
      fill_done <= 1'b0;

      // Non-blocking reads of mem give read-before-write on any collision.
      if (rd_en)
        for (int w = 0; w < WAYS; w++)
          rd_data[w*DATA_W +: DATA_W] <= mem[rd_set][w][rd_word];

      // Way decode by match, so an out-of-range way index simply hits nothing.
      for (int w = 0; w < WAYS; w++)
        if (wr_en && !wr_blocked && (wr_way == WAY_W'(w)))
          mem[wr_set][w][wr_word] <= wr_data;

      case (state)
        IDLE: begin
          if (fill_start) begin
            fill_set_q <= fill_set;
            fill_way_q <= fill_way;
            cnt        <= '0;
            state      <= FILL;
            fill_busy  <= 1'b1;
          end
        end
        FILL: begin
          if (fill_in_valid) begin
            for (int w = 0; w < WAYS; w++)
              if (fill_way_q == WAY_W'(w))
                mem[fill_set_q][w][cnt] <= fill_data;
            cnt <= cnt + 1'b1;
            if (cnt == WORD_W'(WORDS - 1)) begin
              state     <= IDLE;
              fill_busy <= 1'b0;
              fill_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_data_array_nway.sv
// tb/tb_cache_data_array_nway.sv - self-checking bench for cache_data_array_nway
module tb_cache_data_array_nway;

  localparam int RD_W = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            rd_en;
  logic [5:0]      rd_set;
  logic [2:0]      rd_word;
  logic [RD_W-1:0] rd_data;
  logic            rd_valid;
  logic            wr_en;
  logic [5:0]      wr_set;
  logic            wr_way;
  logic [2:0]      wr_word;
  logic [15:0]     wr_data;
  logic            fill_start;
  logic [5:0]      fill_set;
  logic            fill_way;
  logic            fill_in_valid;
  logic [15:0]     fill_data;
  logic            fill_busy;
  logic            fill_done;

  cache_data_array_nway dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_set(rd_set), .rd_word(rd_word), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way), .wr_word(wr_word), .wr_data(wr_data),
    .fill_start(fill_start), .fill_set(fill_set), .fill_way(fill_way),
    .fill_in_valid(fill_in_valid), .fill_data(fill_data),
    .fill_busy(fill_busy), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd_en;
    logic [5:0]  rd_set;
    logic [2:0]  rd_word;
    logic        wr_en;
    logic [5:0]  wr_set;
    logic        wr_way;
    logic [2:0]  wr_word;
    logic [15:0] wr_data;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[9];

  logic [15:0]     model [64][2][8];
  logic            m_busy;
  logic [5:0]      m_set;
  logic            m_way;
  logic [2:0]      m_cnt;
  logic [RD_W-1:0] last_rd;
  logic [RD_W-1:0] sb[$];
  int              checks = 0;
  int              errors = 0;
  int              done_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic clr();
    rst = 1'b0; rd_en = 1'b0; rd_set = '0; rd_word = '0;
    wr_en = 1'b0; wr_set = '0; wr_way = 1'b0; wr_word = '0; wr_data = '0;
    fill_start = 1'b0; fill_set = '0; fill_way = 1'b0; fill_in_valid = 1'b0; fill_data = '0;
  endtask

  // Predict outputs from the current inputs and model, advance one clock, compare.
  task automatic tick(input bit use_exp, input logic [RD_W-1:0] exp_rd);
    logic [RD_W-1:0] e;
    logic            exp_valid;
    logic            done_e;
    e = '0;
    done_e = 1'b0;
    exp_valid = rd_en && !rst;
    if (rst) begin
      for (int s = 0; s < 64; s++)
        for (int w = 0; w < 2; w++)
          for (int k = 0; k < 8; k++)
            model[s][w][k] = '0;
      m_busy = 1'b0;
      m_cnt = '0;
      last_rd = '0;
    end else begin
      if (rd_en) begin
        if (use_exp) e = exp_rd;
        else for (int w = 0; w < 2; w++) e[w*16 +: 16] = model[rd_set][w][rd_word];
        sb.push_back(e);
      end
      if (m_busy) begin
        if (wr_en && !(wr_set == m_set && wr_way == m_way))
          model[wr_set][wr_way][wr_word] = wr_data;
        if (fill_in_valid) begin
          model[m_set][m_way][m_cnt] = fill_data;
          if (m_cnt == 3'd7) begin
            m_busy = 1'b0;
            done_e = 1'b1;
          end
          m_cnt = m_cnt + 3'd1;
        end
      end else begin
        if (wr_en) model[wr_set][wr_way][wr_word] = wr_data;
        if (fill_start) begin
          m_set = fill_set; m_way = fill_way; m_cnt = '0; m_busy = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
    if (exp_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk("rd_data", rd_data, e);
      last_rd = e;
    end else begin
      chk("rd_data_hold", rd_data, last_rd);
    end
    chk("fill_busy", 32'(fill_busy), 32'(m_busy));
    chk("fill_done", 32'(fill_done), 32'(done_e));
    if (fill_done) done_count++;
  endtask

  task automatic tick0();
    tick(1'b0, '0);
  endtask

  task automatic read_exp(input logic [5:0] s, input logic [2:0] k, input logic [31:0] exp);
    clr(); rd_en = 1'b1; rd_set = s; rd_word = k;
    tick(1'b1, exp);
  endtask

  task automatic start_fill(input logic [5:0] s, input logic w);
    clr(); fill_start = 1'b1; fill_set = s; fill_way = w;
    tick0();
  endtask

  initial begin
    vt[0] = '{1'b1, 6'd5,  3'd3, 1'b0, 6'd0,  1'b0, 3'd0, 16'h0000, 32'h0000_0000};
    vt[1] = '{1'b0, 6'd0,  3'd0, 1'b1, 6'd10, 1'b1, 3'd7, 16'hBEEF, 32'h0000_0000};
    vt[2] = '{1'b1, 6'd10, 3'd7, 1'b0, 6'd0,  1'b0, 3'd0, 16'h0000, 32'hBEEF_0000};
    vt[3] = '{1'b0, 6'd0,  3'd0, 1'b1, 6'd2,  1'b0, 3'd0, 16'h0AAA, 32'h0000_0000};
    vt[4] = '{1'b1, 6'd2,  3'd0, 1'b1, 6'd2,  1'b0, 3'd0, 16'h1234, 32'h0000_0AAA};
    vt[5] = '{1'b1, 6'd2,  3'd0, 1'b0, 6'd0,  1'b0, 3'd0, 16'h0000, 32'h0000_1234};
    vt[6] = '{1'b0, 6'd0,  3'd0, 1'b0, 6'd0,  1'b0, 3'd0, 16'h0000, 32'h0000_0000};
    vt[7] = '{1'b1, 6'd2,  3'd0, 1'b1, 6'd2,  1'b1, 3'd0, 16'h7777, 32'h0000_1234};
    vt[8] = '{1'b1, 6'd2,  3'd0, 1'b0, 6'd0,  1'b0, 3'd0, 16'h0000, 32'h7777_1234};

    clr();
    m_set = '0; m_way = 1'b0;
    rst = 1'b1; tick0();
    rst = 1'b1; tick0();

    for (int i = 0; i < 9; i++) begin
      clr();
      rd_en = vt[i].rd_en; rd_set = vt[i].rd_set; rd_word = vt[i].rd_word;
      wr_en = vt[i].wr_en; wr_set = vt[i].wr_set; wr_way = vt[i].wr_way;
      wr_word = vt[i].wr_word; wr_data = vt[i].wr_data;
      tick(1'b1, vt[i].exp_rd);
    end

    // Gapped fill of set 63 way 1; fill_in_valid in the start cycle and a second start mid-fill are ignored.
    clr(); fill_start = 1'b1; fill_set = 6'd63; fill_way = 1'b1;
    fill_in_valid = 1'b1; fill_data = 16'hFFFF;
    tick0();
    for (int i = 0; i < 8; i++) begin
      clr(); fill_in_valid = 1'b1; fill_data = 16'(16'h1000 + i);
      if (i == 3) begin fill_start = 1'b1; fill_set = 6'd0; fill_way = 1'b0; end
      tick0();
      if (i < 7) begin clr(); tick0(); end
    end
    clr(); tick0();
    chk("done_count_a", 32'(done_count), 32'd1);
    for (int i = 0; i < 8; i++)
      read_exp(6'd63, 3'(i), {16'(16'h1000 + i), 16'h0000});
    read_exp(6'd0, 3'd0, 32'h0000_0000);

    // Fill of set 4 way 0 with store hits to the owned line and to the sibling way.
    start_fill(6'd4, 1'b0);
    for (int i = 0; i < 8; i++) begin
      clr(); fill_in_valid = 1'b1; fill_data = 16'(16'h4000 + i);
      if (i == 3) begin wr_en = 1'b1; wr_set = 6'd4; wr_way = 1'b0; wr_word = 3'd2; wr_data = 16'hDEAD; end
      if (i == 4) begin wr_en = 1'b1; wr_set = 6'd4; wr_way = 1'b1; wr_word = 3'd2; wr_data = 16'h5555; end
      tick0();
    end
    // fill_start in the fill_done cycle must be accepted.
    start_fill(6'd7, 1'b1);
    chk("done_count_b", 32'(done_count), 32'd2);
    for (int i = 0; i < 8; i++) begin
      clr(); fill_in_valid = 1'b1; fill_data = 16'(16'h7000 + i);
      tick0();
    end
    clr(); tick0();
    read_exp(6'd4, 3'd2, 32'h5555_4002);
    read_exp(6'd4, 3'd7, 32'h0000_4007);
    read_exp(6'd7, 3'd5, 32'h7005_0000);

    // Reset mid-fill abandons the fill and clears storage.
    start_fill(6'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      clr(); fill_in_valid = 1'b1; fill_data = 16'(16'h9000 + i);
      tick0();
    end
    clr(); rst = 1'b1; tick0();
    clr(); tick0();
    chk("done_count_c", 32'(done_count), 32'd3);
    for (int i = 0; i < 3; i++)
      read_exp(6'd9, 3'(i), 32'h0000_0000);
    read_exp(6'd63, 3'd0, 32'h0000_0000);
    read_exp(6'd10, 3'd7, 32'h0000_0000);
    start_fill(6'd9, 1'b1);
    for (int i = 0; i < 8; i++) begin
      clr(); fill_in_valid = 1'b1; fill_data = 16'(16'h9100 + i);
      tick0();
    end
    clr(); tick0();
    chk("done_count_d", 32'(done_count), 32'd4);
    read_exp(6'd9, 3'd2, 32'h9102_0000);
    read_exp(6'd9, 3'd7, 32'h9107_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_data_array_nway.md
Name: cache_data_array_nway

Overview:
- Parametrised N-way set-associative cache data store; the next generation of the 2-way/64-set/8-word data array.
- Adds a registered read port that returns all ways in parallel, a single-word write port for store hits, and a built-in block-fill sequencer that streams a whole line from memory into a chosen set/way.
- Sits between the cache controller (tag compare, LRU, miss FSM) and the memory interface.

Parameters:
- SETS, 64: number of sets; must be a power of two. SET_W = clog2(SETS).
- WAYS, 2: ways per set; must be ≥1. WAY_W = max(1, clog2(WAYS)).
- WORDS, 8: words per block; must be a power of two and ≥2. WORD_W = clog2(WORDS).
- DATA_W, 16: bits per word.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  read request.
- rd_set  in  SET_W  read set index.
- rd_word  in  WORD_W  read word offset.
- rd_data  out  WAYS*DATA_W  registered read data; way w occupies bits [w*DATA_W +: DATA_W].
- rd_valid  out  1  rd_data is valid this cycle.
- wr_en  in  1  single-word write (store hit).
- wr_set  in  SET_W  write set index.
- wr_way  in  WAY_W  write way.
- wr_word  in  WORD_W  write word offset.
- wr_data  in  DATA_W  write data.
- fill_start  in  1  begin a line fill.
- fill_set  in  SET_W  set to fill; sampled only with fill_start.
- fill_way  in  WAY_W  way to fill; sampled only with fill_start.
- fill_in_valid  in  1  fill_data carries the next word.
- fill_data  in  DATA_W  fill word.
- fill_busy  out  1  fill sequencer is active.
- fill_done  out  1  one-cycle pulse when a fill completes.

Behaviour:
- Reset (synchronous, active-high) sets every storage word, rd_data, rd_valid, fill_busy and fill_done to 0. The FSM goes to IDLE and the word counter to 0. Reset mid-fill abandons the fill; no fill_done is produced.
- Read: latency 1. If rd_en is high in cycle N, rd_valid=1 and rd_data holds all WAYS words at (rd_set, rd_word) in cycle N+1. If rd_en is low, rd_valid=0 next cycle and rd_data holds its last value.
- Read/write collision: the read returns the pre-write contents (read-before-write). This applies to both the wr port and the fill path.
- Write: when wr_en is high, wr_data is stored at (wr_set, wr_way, wr_word) at the clock edge. Only that word changes.
- Fill FSM states are IDLE and FILL.
  - IDLE: fill_start=1 latches fill_set and fill_way, clears the counter and moves to FILL. fill_in_valid is ignored in the fill_start cycle.
  - FILL: fill_busy=1. Each cycle with fill_in_valid=1 writes fill_data to (latched set, latched way, counter), then increments the counter.
  - When the word at counter=WORDS-1 is accepted, the FSM returns to IDLE. In the following cycle fill_busy=0 and fill_done=1 for exactly one cycle.
  - Gaps in fill_in_valid simply stall the counter; there is no timeout.
  - fill_start while in FILL is ignored, and the latched set/way stay unchanged.
  - fill_start in the fill_done cycle is accepted.
- Write vs fill: while in FILL, a wr_en targeting the latched set and way is dropped (the fill owns the line). A wr_en to any other set/way is performed normally, in parallel with the fill write.
- Index widths are exact, so no out-of-range handling is needed. If WAYS is not a power of two, a wr_way ≥ WAYS drops the write, and a latched fill_way ≥ WAYS makes the fill run its full sequence (including fill_done) with no storage update.

Test Plan:
- Reset, then rd_en with set=5, word=3 → rd_valid=1 one cycle later and rd_data=0 for every way.
- wr_en set=10, way=1, word=7, data=0xBEEF; next cycle rd_en set=10, word=7 → way1=0xBEEF, way0=0x0000.
- Same-cycle wr_en and rd_en at set=2, way=0, word=0, data=0x1234, where the word previously held 0x0AAA → rd_data way0=0x0AAA; the next read returns 0x1234.
- fill_start set=63, way=1, then 8 words 0x1000..0x1007 with fill_in_valid gapped every other cycle → fill_done pulses once, one cycle after the 8th word, with fill_busy falling in that same cycle. Reads of words 0–7 return 0x1000..0x1007. A second fill_start issued mid-fill is ignored.
- During a fill of set 4 way 0: wr_en to set 4 way 0 word 2 is dropped (the fill value remains); wr_en to set 4 way 1 word 2 = 0x5555 succeeds.
- rst asserted after 3 fill words → fill_busy=0, no fill_done pulse, all words read back 0. A new fill_start then completes normally.
